// File: rtl/op_dispatch_queue_pkg.sv
// Shared types for the op dispatch queue: op payload, dispatch FSM states, default depth.
package op_dispatch_queue_pkg;

  localparam int unsigned DEPTH_DEFAULT = 8;
  localparam int unsigned OPCODE_W      = 4;
  localparam int unsigned ARG_W         = 16;

  // Decoded op as produced by the command parser
  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [ARG_W-1:0]    arg;
  } op_st;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    FIRE      = 2'd2,
    WAIT_DONE = 2'd3
  } dispatch_state_e;

endpackage

// File: rtl/op_dispatch_queue_fifo.sv
// Clock-enabled synchronous FIFO of op_st with flush; head is read combinationally.
module op_dispatch_queue_fifo
  import op_dispatch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = DEPTH_DEFAULT,
  parameter int unsigned CNT_BITS = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clk_en,
  input  logic                push,
  input  logic                pop,
  input  logic                flush,
  input  op_st                wdata,
  output op_st                rdata,
  output logic [CNT_BITS-1:0] count,
  output logic                full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_BITS-1:0] count_q, count_d;
  logic                do_push, do_pop;
  op_st                mem_q [DEPTH];

  // Full blocks pushes even when a pop lands in the same cycle
  assign full    = (count_q == CNT_BITS'(DEPTH));
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & (count_q != '0);
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Next pointers and occupancy; flush drops everything not yet popped
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (flush) begin
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
    end else if (do_push && !do_pop) begin
      count_d = count_q + CNT_BITS'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CNT_BITS'(1);
    end
  end

  // Pointer and count registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clk_en) begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (clk_en && do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/op_dispatch_queue.sv
// Queues parser ops and hands them one at a time to the processor with a trigger/done handshake.
module op_dispatch_queue
  import op_dispatch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = DEPTH_DEFAULT,
  parameter int unsigned CNT_BITS = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clk_en,
  input  op_st                in_op,
  input  logic                in_valid,
  output logic                in_rdy,
  input  logic                flush,
  output op_st                proc_op,
  output logic                proc_trigger,
  input  logic                proc_rdy,
  input  logic                proc_done,
  output logic [CNT_BITS-1:0] count,
  output logic                busy,
  output logic                empty
);

  dispatch_state_e     state_q;
  op_st                proc_op_q;
  op_st                fifo_rdata;
  logic                fifo_full;
  logic                fifo_pop;
  logic [CNT_BITS-1:0] fifo_count;

  // Reset term keeps in_rdy low while reset is held even though count reads 0
  assign in_rdy   = reset & clk_en & ~flush & ~fifo_full;
  assign fifo_pop = clk_en & (state_q == LOAD);

  op_dispatch_queue_fifo #(
    .DEPTH    (DEPTH),
    .CNT_BITS (CNT_BITS)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .push   (in_valid & in_rdy),
    .pop    (fifo_pop),
    .flush  (flush),
    .wdata  (in_op),
    .rdata  (fifo_rdata),
    .count  (fifo_count),
    .full   (fifo_full)
  );

  // Dispatch FSM and issued-op register; a flush in IDLE suppresses the LOAD so no empty pop occurs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      proc_op_q <= '0;
    end else if (clk_en) begin
      case (state_q)
        IDLE: begin
          if ((fifo_count != '0) && proc_rdy && !flush) state_q <= LOAD;
        end
        LOAD: begin
          proc_op_q <= fifo_rdata;
          state_q   <= FIRE;
        end
        FIRE: begin
          state_q <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (proc_done) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Trigger is qualified by clk_en so it lasts one clk cycle even with a sparse enable
  assign proc_trigger = clk_en & (state_q == FIRE);
  assign proc_op      = proc_op_q;
  assign count        = fifo_count;
  assign busy         = (state_q != IDLE);
  assign empty        = (fifo_count == '0) & ~busy;

endmodule

// File: tb/tb_op_dispatch_queue.sv
// Directed self-checking bench for op_dispatch_queue with a small processor responder.
module tb_op_dispatch_queue;
  import op_dispatch_queue_pkg::*;

  localparam int unsigned DEPTH    = 8;
  localparam int unsigned CNT_BITS = 4;

  logic                clk;
  logic                reset;
  logic                clk_en;
  op_st                in_op;
  logic                in_valid;
  logic                in_rdy;
  logic                flush;
  op_st                proc_op;
  logic                proc_trigger;
  logic                proc_rdy;
  logic                proc_done;
  logic [CNT_BITS-1:0] count;
  logic                busy;
  logic                empty;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   en_mode = 0;
  int   en_ph = 0;
  int   resp_lat = 2;
  int   trig_viol = 0;
  logic prev_trig = 1'b0;
  op_st trig_op[$];
  int   trig_cyc[$];
  int   done_cyc[$];
  int   p, b, db, acc;

  op_dispatch_queue #(.DEPTH(DEPTH), .CNT_BITS(CNT_BITS)) dut (
    .clk          (clk),
    .reset        (reset),
    .clk_en       (clk_en),
    .in_op        (in_op),
    .in_valid     (in_valid),
    .in_rdy       (in_rdy),
    .flush        (flush),
    .proc_op      (proc_op),
    .proc_trigger (proc_trigger),
    .proc_rdy     (proc_rdy),
    .proc_done    (proc_done),
    .count        (count),
    .busy         (busy),
    .empty        (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Trigger log, plus width / enable-qualification check
  always @(negedge clk) begin
    if (proc_trigger) begin
      trig_op.push_back(proc_op);
      trig_cyc.push_back(cyc);
      if (!clk_en || prev_trig) trig_viol <= trig_viol + 1;
    end
    prev_trig <= proc_trigger;
  end

  // Clock-enable pattern: always on, or one cycle in four
  initial begin
    clk_en = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      en_ph = en_ph + 1;
      clk_en = (en_mode != 0) ? ((en_ph % 4) == 0) : 1'b1;
    end
  end

  // Processor model: done resp_lat cycles after trigger, held until an enabled cycle
  initial begin : responder
    logic en_s;
    proc_done = 1'b0;
    forever begin
      @(negedge clk);
      if (proc_trigger) begin
        repeat (resp_lat) @(posedge clk);
        #1 proc_done = 1'b1;
        en_s = 1'b0;
        while (!en_s) begin
          @(negedge clk);
          en_s = clk_en;
          if (en_s) done_cyc.push_back(cyc);
          @(posedge clk);
        end
        #1 proc_done = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic op_st mk(input int i);
    op_st o;
    o.opcode = 4'(i);
    o.arg    = 16'(i * 37 + 5);
    return o;
  endfunction

  task automatic push_op(input op_st o);
    logic ok;
    ok = 1'b0;
    in_op = o;
    in_valid = 1'b1;
    for (int g = 0; g < 40 && !ok; g++) begin
      #1;
      ok = in_rdy;
      @(posedge clk);
      #2;
    end
    in_valid = 1'b0;
    chk("push_accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    for (int g = 0; g < budget && !empty; g++) tick();
    chk("idle_wait", 32'(empty), 32'd1);
  endtask

  task automatic wait_trigs(input int n, input int budget);
    for (int g = 0; g < budget && trig_op.size() < n; g++) tick();
    chk("trig_wait", 32'(trig_op.size() >= n), 32'd1);
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_op = '0; flush = 1'b0; proc_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    // reset values
    chk("rst_trigger", 32'(proc_trigger), 32'd0);
    chk("rst_busy",    32'(busy),         32'd0);
    chk("rst_empty",   32'(empty),        32'd1);
    chk("rst_count",   32'(count),        32'd0);
    chk("rst_in_rdy",  32'(in_rdy),       32'd0);
    chk("rst_proc_op", 32'(proc_op),      32'd0);
    reset = 1'b1;
    tick();
    chk("idle_in_rdy", 32'(in_rdy), 32'd1);
    chk("idle_empty",  32'(empty),  32'd1);

    // single op: trigger 3 cycles after the push, op held, empty after done
    proc_rdy = 1'b1; resp_lat = 3; b = trig_op.size();
    in_op = mk(1); in_valid = 1'b1;
    #1;
    chk("single_in_rdy", 32'(in_rdy), 32'd1);
    p = cyc;
    tick(); in_valid = 1'b0;
    chk("single_c1_count", 32'(count), 32'd1);
    chk("single_c1_busy",  32'(busy),  32'd0);
    tick();
    chk("single_c2_busy", 32'(busy),         32'd1);
    chk("single_c2_trig", 32'(proc_trigger), 32'd0);
    tick();
    chk("single_c3_trig",  32'(proc_trigger), 32'd1);
    chk("single_c3_op",    32'(proc_op),      32'(mk(1)));
    chk("single_c3_count", 32'(count),        32'd0);
    tick();
    chk("single_c4_trig", 32'(proc_trigger), 32'd0);
    chk("single_c4_op",   32'(proc_op),      32'(mk(1)));
    tick(); tick();
    chk("single_c6_done", 32'(proc_done), 32'd1);
    chk("single_c6_busy", 32'(busy),      32'd1);
    tick();
    chk("single_c7_busy",  32'(busy),    32'd0);
    chk("single_c7_empty", 32'(empty),   32'd1);
    chk("single_keep_op",  32'(proc_op), 32'(mk(1)));
    chk("single_ntrig",    32'(trig_op.size()), 32'(b + 1));
    chk("single_trig_cyc", 32'(trig_cyc[b]),    32'(p + 3));

    // burst of 10 into a stalled processor, then drain in order
    proc_rdy = 1'b0; resp_lat = 2; b = trig_op.size(); db = done_cyc.size(); acc = 0;
    for (int i = 0; i < 10; i++) begin
      in_op = mk(10 + i); in_valid = 1'b1;
      #1;
      if (in_rdy) acc++;
      @(posedge clk);
      #2;
    end
    in_valid = 1'b0;
    chk("burst_accepted", 32'(acc),    32'd8);
    chk("burst_count",    32'(count),  32'd8);
    chk("burst_full_rdy", 32'(in_rdy), 32'd0);
    chk("burst_busy",     32'(busy),   32'd0);
    proc_rdy = 1'b1;
    push_op(mk(18));
    push_op(mk(19));
    wait_trigs(b + 10, 400);
    wait_idle(100);
    for (int k = 0; k < 10; k++) chk("burst_order", 32'(trig_op[b + k]), 32'(mk(10 + k)));
    for (int k = 0; k < 9; k++) chk("done_to_trig", 32'(trig_cyc[b + k + 1]), 32'(done_cyc[db + k] + 3));

    // flush in the LOAD cycle: popped op still issues, the other is dropped
    resp_lat = 2; b = trig_op.size();
    in_op = mk(40); in_valid = 1'b1;
    tick();
    in_op = mk(41);
    tick();
    in_valid = 1'b0;
    chk("fl_load_busy",  32'(busy),  32'd1);
    chk("fl_load_count", 32'(count), 32'd2);
    flush = 1'b1;
    #1;
    chk("fl_load_in_rdy", 32'(in_rdy), 32'd0);
    tick();
    flush = 1'b0;
    chk("fl_load_trig",  32'(proc_trigger), 32'd1);
    chk("fl_load_op",    32'(proc_op),      32'(mk(40)));
    chk("fl_load_count2", 32'(count),       32'd0);
    wait_idle(60);
    repeat (5) tick();
    chk("fl_load_ntrig", 32'(trig_op.size()), 32'(b + 1));

    // flush with 5 queued and one in flight
    resp_lat = 20; b = trig_op.size();
    for (int i = 0; i < 6; i++) begin
      in_op = mk(20 + i); in_valid = 1'b1;
      tick();
    end
    in_op = mk(99); flush = 1'b1;
    #1;
    chk("fl_q_count5", 32'(count),  32'd5);
    chk("fl_q_busy",   32'(busy),   32'd1);
    chk("fl_q_in_rdy", 32'(in_rdy), 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_q_count0",  32'(count), 32'd0);
    chk("fl_q_busy2",   32'(busy),  32'd1);
    chk("fl_q_empty0",  32'(empty), 32'd0);
    wait_idle(80);
    repeat (8) tick();
    chk("fl_q_ntrig",  32'(trig_op.size()), 32'(b + 1));
    chk("fl_q_op",     32'(trig_op[b]),     32'(mk(20)));
    chk("fl_q_count_end", 32'(count), 32'd0);

    // sparse clock enable: same ordering, single-cycle enabled trigger
    en_mode = 1; resp_lat = 1; b = trig_op.size();
    push_op(mk(60));
    push_op(mk(61));
    push_op(mk(62));
    wait_trigs(b + 3, 300);
    wait_idle(300);
    repeat (8) tick();
    chk("en_ntrig", 32'(trig_op.size()), 32'(b + 3));
    for (int k = 0; k < 3; k++) chk("en_order", 32'(trig_op[b + k]), 32'(mk(60 + k)));
    chk("trig_width", 32'(trig_viol), 32'd0);
    en_mode = 0;
    repeat (4) tick();

    // reset in WAIT_DONE with 3 queued
    proc_rdy = 1'b1; resp_lat = 60; b = trig_op.size();
    for (int i = 0; i < 4; i++) begin
      in_op = mk(70 + i); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("mid_count3", 32'(count), 32'd3);
    chk("mid_busy",   32'(busy),  32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_trig",   32'(proc_trigger), 32'd0);
    chk("mid_rst_count",  32'(count),        32'd0);
    chk("mid_rst_empty",  32'(empty),        32'd1);
    chk("mid_rst_busy",   32'(busy),         32'd0);
    chk("mid_rst_in_rdy", 32'(in_rdy),       32'd0);
    chk("mid_rst_op",     32'(proc_op),      32'd0);
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("post_rst_busy",  32'(busy),   32'd0);
    chk("post_rst_empty", 32'(empty),  32'd1);
    chk("post_rst_rdy",   32'(in_rdy), 32'd1);
    repeat (5) tick();
    chk("post_rst_ntrig", 32'(trig_op.size()), 32'(b + 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
